inst_fetch_queue: RTL and testbench

Parametrised instruction-fetch front end. It generates sequential PCs, issues read requests to instruction memory over a valid/ready channel, and accepts in-order responses of variable latency. Returned instructions are buffered in a prefetch FIFO and handed to decode with their PCs. Jumps redirect the PC, flush the FIFO and discard responses still in flight. The block sits between the PC source (branch/jump resolution) and the decode stage.

---
 rtl/inst_fetch_queue.sv | 108 ++++++++++
 tb/tb_inst_fetch_queue.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Instruction-fetch front end: sequential PC generation, credit-limited memory
// requests, in-order response capture into a prefetch FIFO, and jump redirect/flush.
module inst_fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         hold,
  input  logic                         jump_flag,
  input  logic [ADDR_W-1:0]            jump_addr,
  output logic                         imem_req_valid,
  input  logic                         imem_req_ready,
  output logic [ADDR_W-1:0]            imem_req_addr,
  input  logic                         imem_rsp_valid,
  input  logic [DATA_W-1:0]            imem_rsp_data,
  output logic                         id_valid,
  input  logic                         id_ready,
  output logic [ADDR_W-1:0]            id_pc,
  output logic [DATA_W-1:0]            id_inst,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] rsp_pc;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  discard;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [ADDR_W-1:0] fifo_pc   [DEPTH];
  logic [DATA_W-1:0] fifo_inst [DEPTH];

  logic              credit_ok;
  logic              req_fire;
  logic              push;
  logic              pop;
  logic              rsp_drop;
  logic [CNT_W-1:0]  rsp_dec;
  logic [CNT_W-1:0]  live_after_rsp;

  // Credits cover both buffered and in-flight entries, so every response has a slot.
  always_comb begin
    credit_ok      = ({1'b0, count} + {1'b0, outstanding}) < (CNT_W + 1)'(DEPTH);
    imem_req_valid = rst && !hold && !jump_flag && credit_ok;
    imem_req_addr  = pc;
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_dec        = CNT_W'(imem_rsp_valid);
    live_after_rsp = outstanding - rsp_dec;
    rsp_drop       = imem_rsp_valid && (discard != '0);
    push           = imem_rsp_valid && !jump_flag && (discard == '0);
    id_valid       = !hold && (count != '0);
    pop            = id_valid && id_ready && !jump_flag;
    id_pc          = fifo_pc[rd_ptr];
    id_inst        = fifo_inst[rd_ptr];
    fifo_count     = count;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_pc[i]   <= '0;
        fifo_inst[i] <= '0;
      end
    end else if (jump_flag) begin
      // Everything still in flight after this cycle's response belongs to the old stream.
      pc          <= jump_addr;
      rsp_pc      <= jump_addr;
      outstanding <= live_after_rsp;
      discard     <= live_after_rsp;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      if (req_fire) begin
        pc <= pc + ADDR_W'(PC_STEP);
      end
      if (push) begin
        fifo_pc[wr_ptr]   <= rsp_pc;
        fifo_inst[wr_ptr] <= imem_rsp_data;
        wr_ptr            <= wr_ptr + 1'b1;
        rsp_pc            <= rsp_pc + ADDR_W'(PC_STEP);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (rsp_drop) begin
        discard <= discard - 1'b1;
      end
      count       <= count + CNT_W'(push) - CNT_W'(pop);
      outstanding <= outstanding + CNT_W'(req_fire) - rsp_dec;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: 32-bit instance behind a fixed-latency
// memory model, plus an 8-bit instance for PC wrap and asynchronous reset.
module tb_inst_fetch_queue;

  logic        clk;
  logic        rst;
  logic        hold;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [2:0]  fifo_count;

  logic        rst8;
  logic        hold8;
  logic        jump8;
  logic [7:0]  jump_addr8;
  logic        req_valid8;
  logic        req_ready8;
  logic [7:0]  req_addr8;
  logic        rsp_valid8;
  logic [31:0] rsp_data8;
  logic        id_valid8;
  logic        id_ready8;
  logic [7:0]  id_pc8;
  logic [31:0] id_inst8;
  logic [2:0]  fifo_count8;

  int checks = 0;
  int errors = 0;
  int lat = 1;
  int req_cnt;

  logic        slot_v [8];
  logic [31:0] slot_a [8];
  logic [7:0]  rsp_a8;

  inst_fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0), .PC_STEP(4)) u_dut (
    .clk(clk), .rst(rst), .hold(hold), .jump_flag(jump_flag), .jump_addr(jump_addr),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_inst(id_inst),
    .fifo_count(fifo_count)
  );

  inst_fetch_queue #(.ADDR_W(8), .DATA_W(32), .DEPTH(4), .RESET_PC(8'hF4), .PC_STEP(4)) u_dut8 (
    .clk(clk), .rst(rst8), .hold(hold8), .jump_flag(jump8), .jump_addr(jump_addr8),
    .imem_req_valid(req_valid8), .imem_req_ready(req_ready8), .imem_req_addr(req_addr8),
    .imem_rsp_valid(rsp_valid8), .imem_rsp_data(rsp_data8),
    .id_valid(id_valid8), .id_ready(id_ready8), .id_pc(id_pc8), .id_inst(id_inst8),
    .fifo_count(fifo_count8)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Fixed-latency in-order memory, reset together with the DUT.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        slot_v[i] <= 1'b0;
        slot_a[i] <= '0;
      end
      req_cnt <= 0;
    end else begin
      for (int i = 0; i < 7; i++) begin
        slot_v[i] <= slot_v[i+1];
        slot_a[i] <= slot_a[i+1];
      end
      slot_v[7]     <= 1'b0;
      slot_v[lat-1] <= imem_req_valid && imem_req_ready;
      slot_a[lat-1] <= imem_req_addr;
      req_cnt       <= req_cnt + ((imem_req_valid && imem_req_ready) ? 1 : 0);
    end
  end
  assign imem_rsp_valid = slot_v[0];
  assign imem_rsp_data  = word(slot_a[0]);

  always @(posedge clk or negedge rst8) begin
    if (!rst8) begin
      rsp_valid8 <= 1'b0;
      rsp_a8     <= '0;
    end else begin
      rsp_valid8 <= req_valid8 && req_ready8;
      rsp_a8     <= req_addr8;
    end
  end
  assign rsp_data8 = {24'h0, rsp_a8};

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 0: the first cycle after reset is released.
  task automatic do_reset(input int latency, input logic ready);
    rst = 1'b0; hold = 1'b0; jump_flag = 1'b0; jump_addr = '0;
    imem_req_ready = 1'b1; id_ready = ready; lat = latency;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; hold = 1'b0; jump_flag = 1'b0; jump_addr = '0;
    imem_req_ready = 1'b1; id_ready = 1'b1;
    #12;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %b exp 0", imem_req_valid); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid got %b exp 0", id_valid); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_fifo_count got %0d exp 0", fifo_count); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL reset_id_pc got %h exp 0", id_pc); end
    checks++; if (id_inst !== 32'h0) begin errors++; $display("FAIL reset_id_inst got %h exp 0", id_inst); end
  endtask

  task automatic test_streaming();
    logic [31:0] exp_pc;
    do_reset(1, 1'b1);
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin errors++; $display("FAIL stream_first_req got v=%b a=%h exp v=1 a=0", imem_req_valid, imem_req_addr); end
    for (int c = 1; c < 10; c++) begin
      next_cycle();
      #1;
      if (c < 2) begin
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL stream_early_valid c=%0d got %b exp 0", c, id_valid); end
      end else begin
        exp_pc = 32'(4 * (c - 2));
        checks++; if (id_valid !== 1'b1 || id_pc !== exp_pc || id_inst !== word(exp_pc)) begin
          errors++; $display("FAIL stream_id c=%0d got v=%b pc=%h inst=%h exp v=1 pc=%h inst=%h", c, id_valid, id_pc, id_inst, exp_pc, word(exp_pc));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset(1, 1'b0);
    for (int c = 0; c < 10; c++) next_cycle();
    #1;
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL bp_fifo_count got %0d exp 4", fifo_count); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid got %b exp 0", imem_req_valid); end
    checks++; if (req_cnt !== 4) begin errors++; $display("FAIL bp_req_cnt got %0d exp 4", req_cnt); end
    id_ready = 1'b1;
    #1;
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0) begin errors++; $display("FAIL bp_drain0 got v=%b pc=%h exp v=1 pc=0", id_valid, id_pc); end
    for (int j = 1; j <= 4; j++) begin
      next_cycle();
      #1;
      checks++; if (id_valid !== 1'b1 || id_pc !== 32'(4 * j)) begin errors++; $display("FAIL bp_drain j=%0d got v=%b pc=%h exp v=1 pc=%h", j, id_valid, id_pc, 32'(4 * j)); end
      if (j == 1) begin
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) begin errors++; $display("FAIL bp_resume got v=%b a=%h exp v=1 a=10", imem_req_valid, imem_req_addr); end
      end
    end
  endtask

  task automatic test_jump_inflight();
    int n;
    do_reset(3, 1'b1);
    next_cycle();
    next_cycle();
    jump_flag = 1'b1; jump_addr = 32'h100;
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL jif_req_in_jump got %b exp 0", imem_req_valid); end
    checks++; if (req_cnt !== 2) begin errors++; $display("FAIL jif_outstanding_reqs got %0d exp 2", req_cnt); end
    next_cycle();
    jump_flag = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin errors++; $display("FAIL jif_redirect got v=%b a=%h exp v=1 a=100", imem_req_valid, imem_req_addr); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL jif_flush got %0d exp 0", fifo_count); end
    n = 3;
    while (!id_valid && n < 20) begin
      next_cycle();
      #1;
      n++;
    end
    checks++; if (n !== 7) begin errors++; $display("FAIL jif_first_cycle got %0d exp 7", n); end
    checks++; if (id_pc !== 32'h100 || id_inst !== word(32'h100)) begin errors++; $display("FAIL jif_first_id got pc=%h inst=%h exp pc=100 inst=%h", id_pc, id_inst, word(32'h100)); end
    next_cycle();
    #1;
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h104) begin errors++; $display("FAIL jif_second_id got v=%b pc=%h exp v=1 pc=104", id_valid, id_pc); end
  endtask

  task automatic test_jump_rsp_pop();
    do_reset(1, 1'b1);
    for (int c = 0; c < 4; c++) next_cycle();
    jump_flag = 1'b1; jump_addr = 32'h200;
    #1;
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h8) begin errors++; $display("FAIL jrp_presented got v=%b pc=%h exp v=1 pc=8", id_valid, id_pc); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL jrp_req_in_jump got %b exp 0", imem_req_valid); end
    next_cycle();
    jump_flag = 1'b0;
    #1;
    checks++; if (fifo_count !== 3'd0 || id_valid !== 1'b0) begin errors++; $display("FAIL jrp_flush got cnt=%0d v=%b exp cnt=0 v=0", fifo_count, id_valid); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin errors++; $display("FAIL jrp_redirect got v=%b a=%h exp v=1 a=200", imem_req_valid, imem_req_addr); end
    next_cycle();
    #1;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL jrp_no_stale got %b exp 0", id_valid); end
    next_cycle();
    #1;
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h200 || id_inst !== word(32'h200)) begin errors++; $display("FAIL jrp_first_id got v=%b pc=%h inst=%h exp v=1 pc=200 inst=%h", id_valid, id_pc, id_inst, word(32'h200)); end
  endtask

  task automatic test_hold();
    int n;
    do_reset(3, 1'b1);
    next_cycle();
    next_cycle();
    hold = 1'b1;
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL hold_req got %b exp 0", imem_req_valid); end
    for (int c = 0; c < 3; c++) next_cycle();
    #1;
    checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL hold_fifo_count got %0d exp 2", fifo_count); end
    checks++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL hold_blocked got idv=%b reqv=%b exp 0 0", id_valid, imem_req_valid); end
    checks++; if (req_cnt !== 2) begin errors++; $display("FAIL hold_req_cnt got %0d exp 2", req_cnt); end
    next_cycle();
    jump_flag = 1'b1; jump_addr = 32'h300;
    next_cycle();
    jump_flag = 1'b0;
    #1;
    checks++; if (fifo_count !== 3'd0 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL hold_jump got cnt=%0d reqv=%b exp 0 0", fifo_count, imem_req_valid); end
    hold = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300) begin errors++; $display("FAIL hold_redirect got v=%b a=%h exp v=1 a=300", imem_req_valid, imem_req_addr); end
    n = 7;
    while (!id_valid && n < 25) begin
      next_cycle();
      #1;
      n++;
    end
    checks++; if (n !== 11 || id_pc !== 32'h300) begin errors++; $display("FAIL hold_first_id got cyc=%0d pc=%h exp cyc=11 pc=300", n, id_pc); end
  endtask

  task automatic test_wrap_async_reset();
    logic [7:0] exp_pc;
    @(posedge clk);
    #1;
    rst8 = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      next_cycle();
      #1;
      if (c >= 2) begin
        exp_pc = 8'hF4 + 8'(4 * (c - 2));
        checks++; if (id_valid8 !== 1'b1 || id_pc8 !== exp_pc || id_inst8 !== {24'h0, exp_pc}) begin
          errors++; $display("FAIL wrap_id c=%0d got v=%b pc=%h inst=%h exp v=1 pc=%h", c, id_valid8, id_pc8, id_inst8, exp_pc);
        end
      end
    end
    checks++; if (fifo_count8 !== 3'd1) begin errors++; $display("FAIL wrap_count got %0d exp 1", fifo_count8); end
    #2;
    rst8 = 1'b0;
    #1;
    checks++; if (id_valid8 !== 1'b0 || fifo_count8 !== 3'd0) begin errors++; $display("FAIL async_reset got v=%b cnt=%0d exp v=0 cnt=0", id_valid8, fifo_count8); end
    checks++; if (req_valid8 !== 1'b0 || id_pc8 !== 8'h0) begin errors++; $display("FAIL async_reset_req got v=%b pc=%h exp v=0 pc=0", req_valid8, id_pc8); end
  endtask

  initial begin
    rst8 = 1'b0; hold8 = 1'b0; jump8 = 1'b0; jump_addr8 = '0;
    req_ready8 = 1'b1; id_ready8 = 1'b1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_jump_inflight();
    test_jump_rsp_pop();
    test_hold();
    test_wrap_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
